// File: rtl/flex_mac_pe_if.sv
// Operand, forward and result handshake bundle for one systolic MAC processing element.
// master = environment / neighbouring cells, slave = the PE itself.
interface flex_mac_pe_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32
);

  logic              row_in_valid;
  logic              row_in_ready;
  logic [DATA_W-1:0] row_in_dat;
  logic              col_in_valid;
  logic              col_in_ready;
  logic [DATA_W-1:0] col_in_dat;

  logic              row_out_valid;
  logic              row_out_ready;
  logic [DATA_W-1:0] row_out_dat;
  logic              col_out_valid;
  logic              col_out_ready;
  logic [DATA_W-1:0] col_out_dat;

  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  accum_sum;
  logic              comp_done;
  logic              error_bit;
  logic [1:0]        err_code;

  modport master (
    output row_in_valid, row_in_dat, col_in_valid, col_in_dat,
    output row_out_ready, col_out_ready, res_ready,
    input  row_in_ready, col_in_ready,
    input  row_out_valid, row_out_dat, col_out_valid, col_out_dat,
    input  res_valid, accum_sum, comp_done, error_bit, err_code
  );

  modport slave (
    input  row_in_valid, row_in_dat, col_in_valid, col_in_dat,
    input  row_out_ready, col_out_ready, res_ready,
    output row_in_ready, col_in_ready,
    output row_out_valid, row_out_dat, col_out_valid, col_out_dat,
    output res_valid, accum_sum, comp_done, error_bit, err_code
  );

endinterface

// File: rtl/flex_mac_pe.sv
// Output-stationary systolic PE: joint row/col operand intake, 1-cycle east/south forwarding,
// MAC_LAT-deep signed multiply pipeline, K_DEPTH-product accumulation with overflow flag/saturation.
module flex_mac_pe #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned MAC_LAT = 3,
  parameter int unsigned K_DEPTH = 4,
  parameter bit          SAT_EN  = 1'b1
) (
  input logic          clk,
  input logic          n_rst,
  flex_mac_pe_if.slave bus
);

  localparam int unsigned      PROD_W  = 2 * DATA_W;
  localparam int unsigned      CNT_W   = $clog2(K_DEPTH + 1);
  localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(K_DEPTH);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                   state_q;
  logic [CNT_W-1:0]         issued_q;
  logic [DATA_W-1:0]        row_fwd_q;
  logic [DATA_W-1:0]        col_fwd_q;
  logic                     row_vld_q;
  logic                     col_vld_q;
  logic [MAC_LAT-1:0]       pv_q;
  logic signed [PROD_W-1:0] prod_q [MAC_LAT];
  logic [ACC_W-1:0]         acc_q;
  logic [ACC_W-1:0]         acc_d;
  logic                     err_q;
  logic                     err_d;
  logic [1:0]               code_q;
  logic [1:0]               code_d;
  logic                     res_valid_q;
  logic                     comp_done_q;

  logic                     in_ready_c;
  logic                     fire_c;
  logic                     res_hs_c;
  logic [CNT_W-1:0]         issued_inc_c;
  logic signed [PROD_W-1:0] prod_c;
  logic [ACC_W-1:0]         ext_c;
  logic [ACC_W-1:0]         sum_c;
  logic                     ovf_pos_c;
  logic                     ovf_neg_c;

  // Intake readiness never looks at the *_in_valid inputs; gated by reset so it reads 0 while held.
  assign in_ready_c = n_rst && (state_q == ST_ACCUM) && (issued_q < K_LAST)
                   && (!row_vld_q || bus.row_out_ready)
                   && (!col_vld_q || bus.col_out_ready);
  assign fire_c       = bus.row_in_valid && bus.col_in_valid && in_ready_c;
  assign res_hs_c     = (state_q == ST_DONE) && bus.res_ready;
  assign issued_inc_c = issued_q + CNT_W'(1);
  assign prod_c       = PROD_W'($signed(bus.row_in_dat)) * PROD_W'($signed(bus.col_in_dat));

  // East/south forwarding registers; data only changes on a fire so it is stable under stall.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row_fwd_q <= '0;
      col_fwd_q <= '0;
      row_vld_q <= 1'b0;
      col_vld_q <= 1'b0;
    end else if (fire_c) begin
      row_fwd_q <= bus.row_in_dat;
      col_fwd_q <= bus.col_in_dat;
      row_vld_q <= 1'b1;
      col_vld_q <= 1'b1;
    end else begin
      if (bus.row_out_ready) row_vld_q <= 1'b0;
      if (bus.col_out_ready) col_vld_q <= 1'b0;
    end
  end

  // Multiply pipeline: stage 0 captures the product at the fire edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pv_q <= '0;
      for (int i = 0; i < int'(MAC_LAT); i++) prod_q[i] <= '0;
    end else begin
      pv_q[0] <= fire_c;
      if (fire_c) prod_q[0] <= prod_c;
      for (int i = 1; i < int'(MAC_LAT); i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) prod_q[i] <= prod_q[i-1];
      end
    end
  end

  assign ext_c     = ACC_W'(prod_q[MAC_LAT-1]);
  assign sum_c     = acc_q + ext_c;
  assign ovf_pos_c = !acc_q[ACC_W-1] && !ext_c[ACC_W-1] &&  sum_c[ACC_W-1];
  assign ovf_neg_c =  acc_q[ACC_W-1] &&  ext_c[ACC_W-1] && !sum_c[ACC_W-1];

  // Accumulate the pipeline tail; the first overflow of a result decides err_code.
  always_comb begin
    acc_d  = acc_q;
    err_d  = err_q;
    code_d = code_q;
    if (pv_q[MAC_LAT-1]) begin
      if (SAT_EN && ovf_pos_c) begin
        acc_d = ACC_MAX;
      end else if (SAT_EN && ovf_neg_c) begin
        acc_d = ACC_MIN;
      end else begin
        acc_d = sum_c;
      end
      if (!err_q && (ovf_pos_c || ovf_neg_c)) begin
        err_d  = 1'b1;
        code_d = ovf_pos_c ? 2'b01 : 2'b10;
      end
    end
    if (res_hs_c) begin
      acc_d  = '0;
      err_d  = 1'b0;
      code_d = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q  <= '0;
      err_q  <= 1'b0;
      code_q <= 2'b00;
    end else begin
      acc_q  <= acc_d;
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  // Tile sequencing: ACCUM -> DRAIN once K pairs are issued, DONE once the pipeline is empty.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_ACCUM;
      issued_q    <= '0;
      res_valid_q <= 1'b0;
      comp_done_q <= 1'b0;
    end else begin
      comp_done_q <= 1'b0;
      case (state_q)
        ST_ACCUM: begin
          if (fire_c) begin
            issued_q <= issued_inc_c;
            if (issued_inc_c == K_LAST) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pv_q == '0) begin
            state_q     <= ST_DONE;
            res_valid_q <= 1'b1;
            comp_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            state_q     <= ST_ACCUM;
            issued_q    <= '0;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_ACCUM;
          issued_q    <= '0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.row_in_ready  = in_ready_c;
  assign bus.col_in_ready  = in_ready_c;
  assign bus.row_out_valid = row_vld_q;
  assign bus.row_out_dat   = row_fwd_q;
  assign bus.col_out_valid = col_vld_q;
  assign bus.col_out_dat   = col_fwd_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.accum_sum     = acc_q;
  assign bus.comp_done     = comp_done_q;
  assign bus.error_bit     = err_q;
  assign bus.err_code      = code_q;

endmodule
